// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch stage feeding the main control decoder.
// Holds the PC, fetches one word at a time over a req/ready handshake,
// presents instruction/opcode/PC to decode and computes the next PC on accept.
// Optional macro BUSCA_CONTADOR_EN enables the accepted-instruction counter
// on instr_contadas; without it the port is tied to zero.
module unidade_busca #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
  parameter int unsigned ESPERA_MAX = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_endereco,
  input  logic        mem_pronto,
  input  logic [31:0] mem_dado,
  output logic        instr_valida,
  input  logic        avancar,
  output logic [31:0] instrucao,
  output logic [5:0]  opcode,
  output logic [31:0] pc_atual,
  output logic [31:0] pc_mais4,
  input  logic [2:0]  c_desvio,
  input  logic        zero,
  input  logic [31:0] imediato,
  input  logic [31:0] reg_jr,
  output logic        erro_busca,
  output logic [31:0] instr_contadas
);

  typedef enum logic [1:0] {
    BUSCA   = 2'b00,
    ENTREGA = 2'b01,
    ERRO    = 2'b10
  } estado_t;

  // Last counter value before the fetch is declared lost.
  localparam logic [15:0] LIMITE = 16'(ESPERA_MAX - 32'd1);

  estado_t     estado_r, estado_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [15:0] cnt_r, cnt_s;
  logic        mem_req_r, mem_req_s;
  logic        valida_r, valida_s;
  logic        erro_r, erro_s;
  logic [31:0] pc4_s;
  logic [31:0] desvio_s;
  logic [31:0] alvo_s;

  assign mem_req      = mem_req_r;
  assign mem_endereco = pc_r;
  assign instr_valida = valida_r;
  assign instrucao    = instr_r;
  assign opcode       = instr_r[31:26];
  assign pc_atual     = pc_r;
  assign pc_mais4     = pc4_s;
  assign erro_busca   = erro_r;

  // Next-PC target for the presented instruction, selected by the branch code.
  always_comb begin
    pc4_s    = pc_r + 32'd4;
    desvio_s = pc4_s + (imediato << 2);
    alvo_s   = pc4_s;
    case (c_desvio)
      3'b000:  alvo_s = pc4_s;
      3'b001:  alvo_s = zero ? desvio_s : pc4_s;
      3'b010:  alvo_s = zero ? pc4_s : desvio_s;
      3'b011,
      3'b100:  alvo_s = {pc4_s[31:28], instr_r[25:0], 2'b00};
      3'b101:  alvo_s = reg_jr;
      default: alvo_s = pc4_s;
    endcase
  end

  // Next-state and next-output logic of the fetch FSM.
  always_comb begin
    estado_s  = estado_r;
    pc_s      = pc_r;
    instr_s   = instr_r;
    cnt_s     = cnt_r;
    mem_req_s = mem_req_r;
    valida_s  = valida_r;
    erro_s    = erro_r;
    case (estado_r)
      BUSCA: begin
        if (mem_pronto && mem_req_r) begin
          instr_s   = mem_dado;
          cnt_s     = 16'd0;
          estado_s  = ENTREGA;
          mem_req_s = 1'b0;
          valida_s  = 1'b1;
        end else if (cnt_r == LIMITE) begin
          cnt_s     = 16'd0;
          estado_s  = ERRO;
          mem_req_s = 1'b0;
          erro_s    = 1'b1;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ENTREGA: begin
        if (avancar) begin
          valida_s = 1'b0;
          if (alvo_s[1:0] != 2'b00) begin
            // Misaligned target: keep the PC of the offending instruction.
            estado_s = ERRO;
            erro_s   = 1'b1;
          end else begin
            pc_s      = alvo_s;
            estado_s  = BUSCA;
            mem_req_s = 1'b1;
          end
        end else begin
          estado_s = ENTREGA;
        end
      end
      ERRO: begin
        estado_s  = ERRO;
        mem_req_s = 1'b0;
        valida_s  = 1'b0;
        erro_s    = 1'b1;
      end
      default: begin
        estado_s  = ERRO;
        mem_req_s = 1'b0;
        valida_s  = 1'b0;
        erro_s    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset restarts a fresh fetch at PC_INICIAL.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r  <= BUSCA;
      pc_r      <= PC_INICIAL;
      instr_r   <= 32'd0;
      cnt_r     <= 16'd0;
      mem_req_r <= 1'b1;
      valida_r  <= 1'b0;
      erro_r    <= 1'b0;
    end else begin
      estado_r  <= estado_s;
      pc_r      <= pc_s;
      instr_r   <= instr_s;
      cnt_r     <= cnt_s;
      mem_req_r <= mem_req_s;
      valida_r  <= valida_s;
      erro_r    <= erro_s;
    end
  end

`ifdef BUSCA_CONTADOR_EN
  logic [31:0] contadas_r;

  assign instr_contadas = contadas_r;

  // Counts instructions accepted by decode, wrapping at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      contadas_r <= 32'd0;
    end else if (valida_r && avancar) begin
      contadas_r <= contadas_r + 32'd1;
    end else begin
      contadas_r <= contadas_r;
    end
  end
`else
  assign instr_contadas = 32'd0;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Directed self-checking bench for unidade_busca with a small memory responder
// and a scoreboard of fetched (pc, instruction) pairs.
module tb_unidade_busca;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_endereco;
  logic        mem_pronto;
  logic [31:0] mem_dado;
  logic        instr_valida;
  logic        avancar;
  logic [31:0] instrucao;
  logic [5:0]  opcode;
  logic [31:0] pc_atual;
  logic [31:0] pc_mais4;
  logic [2:0]  c_desvio;
  logic        zero;
  logic [31:0] imediato;
  logic [31:0] reg_jr;
  logic        erro_busca;
  logic [31:0] instr_contadas;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    aceitos = 0;

  unidade_busca #(
    .PC_INICIAL(32'h0000_0000),
    .ESPERA_MAX(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mem_req(mem_req),
    .mem_endereco(mem_endereco),
    .mem_pronto(mem_pronto),
    .mem_dado(mem_dado),
    .instr_valida(instr_valida),
    .avancar(avancar),
    .instrucao(instrucao),
    .opcode(opcode),
    .pc_atual(pc_atual),
    .pc_mais4(pc_mais4),
    .c_desvio(c_desvio),
    .zero(zero),
    .imediato(imediato),
    .reg_jr(reg_jr),
    .erro_busca(erro_busca),
    .instr_contadas(instr_contadas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic aplicar_reset();
    reset      = 1'b1;
    avancar    = 1'b0;
    mem_pronto = 1'b0;
    repeat (2) ciclo();
    reset   = 1'b0;
    aceitos = 0;
    sb.delete();
  endtask

  function automatic logic [31:0] contagem_esperada();
`ifdef BUSCA_CONTADOR_EN
    return 32'(aceitos);
`else
    return 32'd0;
`endif
  endfunction

  // Answer one fetch after 'atraso' wait cycles, then check the presentation.
  task automatic responder(input logic [31:0] addr_exp, input logic [31:0] dado, input int atraso);
    item_t it;
    int    n;
    n = 0;
    while (!mem_req && n < 20) begin
      ciclo();
      n++;
    end
    chk("espera_req", {31'd0, mem_req}, 32'd1);
    chk("endereco", mem_endereco, addr_exp);
    for (int i = 0; i < atraso; i++) begin
      ciclo();
      chk("req_mantido", {31'd0, mem_req}, 32'd1);
    end
    mem_pronto = 1'b1;
    mem_dado   = dado;
    sb.push_back({addr_exp, dado});
    ciclo();
    mem_pronto = 1'b0;
    mem_dado   = 32'hDEAD_BEEF;
    chk("valida", {31'd0, instr_valida}, 32'd1);
    chk("req_baixo", {31'd0, mem_req}, 32'd0);
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk("instrucao", instrucao, it.instr);
      chk("pc_atual", pc_atual, it.pc);
      chk("opcode", {26'd0, opcode}, {26'd0, it.instr[31:26]});
      chk("pc_mais4", pc_mais4, it.pc + 32'd4);
    end
  endtask

  // Accept the presented instruction and check where the next fetch goes.
  task automatic aceitar(input logic [2:0] c, input logic z, input logic [31:0] imm,
                         input logic [31:0] jr, input logic [31:0] addr_exp, input logic espera_erro);
    avancar  = 1'b1;
    c_desvio = c;
    zero     = z;
    imediato = imm;
    reg_jr   = jr;
    ciclo();
    avancar  = 1'b0;
    c_desvio = 3'b111;
    zero     = ~z;
    imediato = 32'h1234_5678;
    reg_jr   = 32'h0000_0003;
    aceitos++;
    chk("valida_pos_aceite", {31'd0, instr_valida}, 32'd0);
    chk("contadas", instr_contadas, contagem_esperada());
    if (espera_erro) begin
      chk("erro_alvo", {31'd0, erro_busca}, 32'd1);
      chk("req_em_erro", {31'd0, mem_req}, 32'd0);
      chk("pc_inalterado", pc_atual, addr_exp);
    end else begin
      chk("req_pos_aceite", {31'd0, mem_req}, 32'd1);
      chk("proximo_pc", mem_endereco, addr_exp);
      chk("sem_erro", {31'd0, erro_busca}, 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    avancar  = 1'b0;
    mem_pronto = 1'b0;
    mem_dado = 32'd0;
    c_desvio = 3'b000;
    zero     = 1'b0;
    imediato = 32'd0;
    reg_jr   = 32'd0;

    // Reset state
    aplicar_reset();
    chk("rst_req", {31'd0, mem_req}, 32'd1);
    chk("rst_end", mem_endereco, 32'h0000_0000);
    chk("rst_valida", {31'd0, instr_valida}, 32'd0);
    chk("rst_erro", {31'd0, erro_busca}, 32'd0);
    chk("rst_instr", instrucao, 32'd0);
    chk("rst_contadas", instr_contadas, 32'd0);

    // Sequential flow, then conditional branches
    responder(32'h0000_0000, 32'h2009_0005, 2);
    chk("opcode_addi", {26'd0, opcode}, {26'd0, 6'b001000});
    aceitar(3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_0004, 1'b0);
    responder(32'h0000_0004, 32'h0000_0020, 1);
    aceitar(3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_0008, 1'b0);
    responder(32'h0000_0008, 32'h1000_FFFE, 0);
    aceitar(3'b001, 1'b1, 32'hFFFF_FFFE, 32'd0, 32'h0000_0004, 1'b0);
    responder(32'h0000_0004, 32'h0000_0020, 0);
    aceitar(3'b000, 1'b1, 32'h0000_0040, 32'd0, 32'h0000_0008, 1'b0);
    responder(32'h0000_0008, 32'h1400_FFFE, 1);
    aceitar(3'b001, 1'b0, 32'hFFFF_FFFE, 32'd0, 32'h0000_000C, 1'b0);
    responder(32'h0000_000C, 32'h1520_0001, 2);
    aceitar(3'b010, 1'b0, 32'h0000_0001, 32'd0, 32'h0000_0014, 1'b0);

    // jr to a far page, then jal there with stall and stray mem_pronto
    responder(32'h0000_0014, 32'h03E0_0008, 0);
    aceitar(3'b101, 1'b0, 32'd0, 32'h4000_0010, 32'h4000_0010, 1'b0);
    responder(32'h4000_0010, 32'h0C00_0040, 1);
    for (int i = 0; i < 10; i++) begin
      mem_pronto = (i == 4);
      mem_dado   = 32'hFFFF_0000;
      ciclo();
      mem_pronto = 1'b0;
      chk("stall_valida", {31'd0, instr_valida}, 32'd1);
      chk("stall_req", {31'd0, mem_req}, 32'd0);
      chk("stall_instr", instrucao, 32'h0C00_0040);
      chk("stall_pc", pc_atual, 32'h4000_0010);
      chk("stall_pc4", pc_mais4, 32'h4000_0014);
    end
    aceitar(3'b100, 1'b0, 32'd0, 32'd0, 32'h4000_0100, 1'b0);

    // Wrap-around of the PC and reserved branch code
    responder(32'h4000_0100, 32'h03E0_0008, 0);
    aceitar(3'b101, 1'b1, 32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    responder(32'hFFFF_FFFC, 32'h0000_0020, 0);
    aceitar(3'b111, 1'b1, 32'h0000_0005, 32'd0, 32'h0000_0000, 1'b0);
    responder(32'h0000_0000, 32'h1520_0010, 0);
    aceitar(3'b010, 1'b1, 32'h0000_0010, 32'd0, 32'h0000_0004, 1'b0);

    // Misaligned jr target -> sticky fault
    responder(32'h0000_0004, 32'h03E0_0008, 0);
    aceitar(3'b101, 1'b0, 32'd0, 32'h0000_0022, 32'h0000_0004, 1'b1);
    for (int i = 0; i < 3; i++) begin
      mem_pronto = 1'b1;
      ciclo();
      chk("erro_fixo", {31'd0, erro_busca}, 32'd1);
      chk("erro_req", {31'd0, mem_req}, 32'd0);
      chk("erro_valida", {31'd0, instr_valida}, 32'd0);
    end
    mem_pronto = 1'b0;
    aplicar_reset();
    chk("erro_limpo", {31'd0, erro_busca}, 32'd0);

    // Memory never answers -> fault after 4 request cycles
    for (int i = 0; i < 4; i++) begin
      chk("to_req", {31'd0, mem_req}, 32'd1);
      chk("to_sem_erro", {31'd0, erro_busca}, 32'd0);
      ciclo();
    end
    chk("to_erro", {31'd0, erro_busca}, 32'd1);
    chk("to_req_baixo", {31'd0, mem_req}, 32'd0);

    // Reset during a pending request; reply arriving under reset is dropped
    aplicar_reset();
    ciclo();
    chk("mr_req", {31'd0, mem_req}, 32'd1);
    reset      = 1'b1;
    mem_pronto = 1'b1;
    mem_dado   = 32'hABCD_0123;
    ciclo();
    mem_pronto = 1'b0;
    ciclo();
    reset   = 1'b0;
    aceitos = 0;
    chk("mr_instr", instrucao, 32'd0);
    chk("mr_valida", {31'd0, instr_valida}, 32'd0);
    chk("mr_end", mem_endereco, 32'h0000_0000);
    chk("mr_req_novo", {31'd0, mem_req}, 32'd1);

    // Three accepts for the instruction counter
    responder(32'h0000_0000, 32'h2009_0001, 1);
    aceitar(3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_0004, 1'b0);
    responder(32'h0000_0004, 32'h2009_0002, 0);
    aceitar(3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_0008, 1'b0);
    responder(32'h0000_0008, 32'h2009_0003, 2);
    aceitar(3'b000, 1'b0, 32'd0, 32'd0, 32'h0000_000C, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
